// File: rtl/barrel_shift_pkg.sv
// Shared encodings and helpers for the pipelined barrel shifter.
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        MODE_LOG = 2'b00,
        MODE_ARI = 2'b01,
        MODE_ROT = 2'b10,
        MODE_RSV = 2'b11
    } shift_mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Control that rides along with each operand so stages never mix fields.
    typedef struct packed {
        logic        dir;
        shift_mode_e mode;
        logic        sign;
    } shift_ctrl_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational shifter level: shifts by 2^LEVEL when enabled.
// The carry tracks the last bit pushed out; composed over all levels this
// equals the last bit shifted out by the total amount, in every mode.
module barrel_shift_level
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] d_in,
    input  logic             c_in,
    input  logic             en,
    input  logic             dir,
    input  shift_mode_e      mode,
    input  logic             sign,
    output logic [WIDTH-1:0] d_out,
    output logic             c_out
);

    localparam int SHIFT = 1 << LEVEL;

    logic             rot;
    logic             fill;
    logic [WIDTH-1:0] sh_right;
    logic [WIDTH-1:0] sh_left;

    // Build both directions, then pick; reserved mode rotates.
    always_comb begin
        rot  = (mode == MODE_ROT) || (mode == MODE_RSV);
        fill = (mode == MODE_ARI) && (dir == DIR_RIGHT) && sign;
        if (rot) begin
            sh_right = {d_in[SHIFT-1:0], d_in[WIDTH-1:SHIFT]};
            sh_left  = {d_in[WIDTH-SHIFT-1:0], d_in[WIDTH-1:WIDTH-SHIFT]};
        end else begin
            sh_right = {{SHIFT{fill}}, d_in[WIDTH-1:SHIFT]};
            sh_left  = {d_in[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        end
        if (en) begin
            d_out = (dir == DIR_LEFT) ? sh_left : sh_right;
            c_out = (dir == DIR_LEFT) ? d_in[WIDTH-SHIFT] : d_in[SHIFT-1];
        end else begin
            d_out = d_in;
            c_out = c_in;
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: LEVELS shift levels split into PIPE register
// groups of GROUP levels each, with a global stall and synchronous flush.
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int GROUP  = 2,
    localparam int LEVELS = clog2(WIDTH),
    localparam int PIPE   = (LEVELS + GROUP - 1) / GROUP
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WIDTH-1:0]  i_in,
    input  logic [LEVELS-1:0] i_amount,
    input  logic              i_dir,
    input  logic [1:0]        i_mode,
    input  logic              i_carry,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WIDTH-1:0]  o_out,
    output logic              o_carry
);

    logic [PIPE-1:0] valid_q;
    logic            stall;

    assign stall   = o_valid & ~i_ready;
    // A flush refuses new input so nothing slips in behind the clear.
    assign o_ready = ~stall & ~i_flush;
    assign o_valid = valid_q[PIPE-1];

    // Valid shift register: flush beats stall, stall holds everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
        end else if (i_flush) begin
            valid_q <= '0;
        end else if (!stall) begin
            valid_q[0] <= i_valid;
            for (int k = 1; k < PIPE; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < PIPE; k++) begin : g_grp
        localparam int LO  = k * GROUP;
        localparam int HI  = ((k + 1) * GROUP < LEVELS) ? (k + 1) * GROUP : LEVELS;
        localparam int N   = HI - LO;
        localparam int REM = LEVELS - LO;

        logic [WIDTH-1:0] src_data;
        logic             src_carry;
        logic [REM-1:0]   src_amt;
        shift_ctrl_t      src_ctrl;
        logic [WIDTH-1:0] data_q;
        logic             carry_q;

        // Only the amount bits not yet consumed travel to later stages.
        if (k == 0) begin : g_head
            assign src_data  = i_in;
            assign src_carry = i_carry;
            assign src_amt   = i_amount;
            assign src_ctrl  = '{dir: i_dir, mode: shift_mode_e'(i_mode), sign: i_in[WIDTH-1]};
        end else begin : g_body
            assign src_data  = g_grp[k-1].data_q;
            assign src_carry = g_grp[k-1].carry_q;
            assign src_amt   = g_grp[k-1].g_ctl.amt_q;
            assign src_ctrl  = g_grp[k-1].g_ctl.ctrl_q;
        end

        for (genvar j = 0; j < N; j++) begin : g_lvl
            logic [WIDTH-1:0] d_in;
            logic [WIDTH-1:0] d_out;
            logic             c_in;
            logic             c_out;

            if (j == 0) begin : g_first
                assign d_in = src_data;
                assign c_in = src_carry;
            end else begin : g_chain
                assign d_in = g_lvl[j-1].d_out;
                assign c_in = g_lvl[j-1].c_out;
            end

            barrel_shift_level #(
                .WIDTH (WIDTH),
                .LEVEL (LO + j)
            ) u_level (
                .d_in  (d_in),
                .c_in  (c_in),
                .en    (src_amt[j]),
                .dir   (src_ctrl.dir),
                .mode  (src_ctrl.mode),
                .sign  (src_ctrl.sign),
                .d_out (d_out),
                .c_out (c_out)
            );
        end

        // Stage data register; contents only matter while its valid is set.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                data_q  <= '0;
                carry_q <= 1'b0;
            end else if (!stall) begin
                data_q  <= g_lvl[N-1].d_out;
                carry_q <= g_lvl[N-1].c_out;
            end
        end

        if (k < PIPE - 1) begin : g_ctl
            logic [REM-N-1:0] amt_q;
            shift_ctrl_t      ctrl_q;

            // Control travels in lockstep with the stage data.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    amt_q  <= '0;
                    ctrl_q <= '0;
                end else if (!stall) begin
                    amt_q  <= src_amt[REM-1:N];
                    ctrl_q <= src_ctrl;
                end
            end
        end
    end

    assign o_out   = g_grp[PIPE-1].data_q;
    assign o_carry = g_grp[PIPE-1].carry_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=32, GROUP=2, PIPE=3).
module tb_barrel_shift_pipe;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_in;
    logic [4:0]  i_amount;
    logic        i_dir;
    logic [1:0]  i_mode;
    logic        i_carry;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_out;
    logic        o_carry;

    typedef struct {
        logic [31:0] d;
        logic        c;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    logic smp_ready;
    logic smp_valid;

    barrel_shift_pipe #(.WIDTH(32), .GROUP(2)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_in     (i_in),
        .i_amount (i_amount),
        .i_dir    (i_dir),
        .i_mode   (i_mode),
        .i_carry  (i_carry),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_out    (o_out),
        .o_carry  (o_carry)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: whole-word arithmetic straight from the shift rules.
    function automatic res_t model(input logic [31:0] a, input int n, input bit dir,
                                   input logic [1:0] mode, input bit cin);
        res_t        r;
        logic [63:0] dbl;
        if (n == 0) begin
            r.d = a;
            r.c = cin;
        end else if (mode[1]) begin
            if (dir) begin
                dbl = {a, a} << n;
                r.d = dbl[63:32];
                r.c = r.d[0];
            end else begin
                dbl = {a, a} >> n;
                r.d = dbl[31:0];
                r.c = r.d[31];
            end
        end else if (dir) begin
            r.d = a << n;
            r.c = a[32-n];
        end else if (mode == 2'b01) begin
            r.d = $signed(a) >>> n;
            r.c = a[n-1];
        end else begin
            r.d = a >> n;
            r.c = a[n-1];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, score transfers, advance.
    task automatic tick(output bit acc);
        res_t e;
        @(negedge i_clk);
        smp_ready = o_ready;
        smp_valid = o_valid;
        acc = i_valid && o_ready;
        if (o_valid && i_ready) begin
            chk("out_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_data", o_out, e.d);
                chk("sb_carry", o_carry, e.c);
            end
            n_out++;
        end
        if (acc) sb.push_back(model(i_in, int'(i_amount), i_dir, i_mode, i_carry));
        if (i_flush) sb.delete();
        @(posedge i_clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [4:0] n,
                            input bit dir, input logic [1:0] mode, input bit cin,
                            input logic [31:0] exp_d, input bit exp_c);
        bit acc;
        i_in = a; i_amount = n; i_dir = dir; i_mode = mode; i_carry = cin;
        i_valid = 1'b1; i_ready = 1'b1; i_flush = 1'b0;
        tick(acc);
        chk({tag, "_accept"}, acc, 1);
        i_valid = 1'b0;
        chk({tag, "_lat1"}, o_valid, 0);
        @(posedge i_clk); #1;
        chk({tag, "_lat2"}, o_valid, 0);
        @(posedge i_clk); #1;
        chk({tag, "_lat3"}, o_valid, 1);
        chk({tag, "_data"}, o_out, exp_d);
        chk({tag, "_carry"}, o_carry, exp_c);
        tick(acc);
    endtask

    initial begin
        bit          acc;
        int          n_acc;
        int          base;
        int          vcount;
        logic [31:0] ops [8];

        i_rst = 1'b0; i_valid = 1'b0; i_in = '0; i_amount = '0; i_dir = 1'b0;
        i_mode = 2'b00; i_carry = 1'b0; i_flush = 1'b0; i_ready = 1'b1;

        // Reset, checked before any clock edge.
        #1 i_rst = 1'b1;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_out", o_out, 0);
        chk("rst_carry", o_carry, 0);
        @(posedge i_clk); #3 i_rst = 1'b0;
        @(posedge i_clk); #1;

        directed("rotr1", 32'h80000001, 5'd1, 1'b0, 2'b10, 1'b0, 32'hC0000000, 1'b1);
        directed("arir31", 32'h80000000, 5'd31, 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 1'b0);
        directed("logr31", 32'h80000000, 5'd31, 1'b0, 2'b00, 1'b0, 32'h00000001, 1'b0);
        directed("logl4", 32'h12345678, 5'd4, 1'b1, 2'b00, 1'b0, 32'h23456780, 1'b1);
        directed("amt0", 32'h12345678, 5'd0, 1'b1, 2'b00, 1'b1, 32'h12345678, 1'b1);
        directed("rsvl8", 32'h12345678, 5'd8, 1'b1, 2'b11, 1'b1, 32'h34567812, 1'b0);

        // Eight back-to-back operands, downstream stalls cycles 3..5.
        for (int i = 0; i < 8; i++) ops[i] = $urandom;
        n_acc = 0;
        base  = n_out;
        for (int cyc = 0; cyc < 40 && (n_acc < 8 || sb.size() != 0); cyc++) begin
            i_ready = !(cyc >= 3 && cyc <= 5);
            if (n_acc < 8) begin
                i_valid = 1'b1; i_in = ops[n_acc]; i_amount = 5'(n_acc * 3 + 1);
                i_dir = n_acc[0]; i_mode = 2'(n_acc); i_carry = 1'b0;
            end else begin
                i_valid = 1'b0;
            end
            tick(acc);
            if (acc) n_acc++;
            if (cyc < 10) chk($sformatf("stall_ready_c%0d", cyc), smp_ready, !(cyc >= 3 && cyc <= 5));
        end
        chk("b2b_count", n_out - base, 8);
        chk("b2b_drained", sb.size(), 0);

        // Flush during a stall with three operands in flight and input offered.
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_in = $urandom; i_amount = 5'($urandom_range(0, 31));
            i_dir = 1'($urandom); i_mode = 2'($urandom); i_carry = 1'($urandom);
            tick(acc);
        end
        i_ready = 1'b0; i_flush = 1'b1;
        tick(acc);
        chk("flush_ready", smp_ready, 0);
        chk("flush_accept", acc, 0);
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            if (smp_valid) vcount++;
        end
        chk("flush_quiet", vcount, 0);
        directed("post_flush", 32'h0F0F00FF, 5'd12, 1'b0, 2'b10, 1'b0, 32'h0FF0F0F0, 1'b0);

        // Random traffic with random backpressure and occasional flushes.
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_valid  = ($urandom_range(0, 3) != 0);
            i_ready  = ($urandom_range(0, 3) != 0);
            i_flush  = ($urandom_range(0, 29) == 0);
            i_in     = $urandom;
            i_amount = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            i_dir    = 1'($urandom);
            i_mode   = 2'($urandom);
            i_carry  = 1'($urandom);
            tick(acc);
        end
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) tick(acc);
        chk("rand_drained", sb.size(), 0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_in = $urandom; i_amount = 5'($urandom_range(1, 31));
            i_dir = 1'($urandom); i_mode = 2'($urandom); i_carry = 1'b0;
            tick(acc);
        end
        i_valid = 1'b0; i_ready = 1'b0;
        chk("arst_pre_valid", o_valid, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_ready", o_ready, 1);
        sb.delete();
        @(posedge i_clk); #1;
        chk("arst_out", o_out, 0);
        chk("arst_carry", o_carry, 0);
        #3 i_rst = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick(acc);
            if (smp_valid) vcount++;
        end
        chk("arst_quiet", vcount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32, meaning data width; SHALL be a power of two, 8..128.
REQ-002 Parameter GROUP, default 2, meaning shift levels per register stage, 1..log2(WIDTH).
REQ-003 Derived constants: LEVELS = log2(WIDTH); PIPE = ceil(LEVELS/GROUP), the number of register stages.
REQ-004 i_clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 i_rst  input  1  reset; asynchronous, active-high.
REQ-006 i_valid  input  1  input operand valid.
REQ-007 o_ready  output  1  block accepts the operand this cycle.
REQ-008 i_in  input  WIDTH  operand.
REQ-009 i_amount  input  LEVELS  shift amount, 0..WIDTH-1.
REQ-010 i_dir  input  1  0 = right, 1 = left.
REQ-011 i_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (behaves as rotate).
REQ-012 i_carry  input  1  carry-in, passed through when the shift amount is 0.
REQ-013 i_flush  input  1  synchronous pipeline flush.
REQ-014 o_valid  output  1  result valid.
REQ-015 i_ready  input  1  downstream accepts the result.
REQ-016 o_out  output  WIDTH  shifted result.
REQ-017 o_carry  output  1  carry-out.

Function
REQ-018 Transfer in = i_valid & o_ready; transfer out = o_valid & i_ready.
REQ-019 Stall = o_valid & ~i_ready; o_ready = ~stall; during a stall every stage (data and valid) SHALL hold.
REQ-020 Latency SHALL be exactly PIPE cycles from transfer in to o_valid with no stalls; throughput SHALL be one operand per cycle.
REQ-021 Stage k SHALL apply amount bits [k*GROUP .. min((k+1)*GROUP, LEVELS)-1], LSB level first; each level SHALL shift by 2^level when its bit is 1.
REQ-022 Logical right SHALL fill with 0. Arithmetic right SHALL fill with i_in[WIDTH-1]. Left logical and left arithmetic SHALL both fill with 0. Rotate SHALL wrap bits modulo WIDTH.
REQ-023 For amount n > 0: left shift o_carry = i_in[WIDTH-n]; right shift o_carry = i_in[n-1]; rotate right o_carry = o_out[WIDTH-1]; rotate left o_carry = o_out[0].
REQ-024 For amount 0: o_out = i_in and o_carry = i_carry in all modes.
REQ-025 Mode, direction and sign SHALL travel with the operand through every stage; operands in flight SHALL never mix control fields.
REQ-026 An i_flush that is not stalled SHALL clear all stage valid bits at the next edge.
REQ-027 When i_flush coincides with i_valid, the input SHALL NOT be accepted, and o_ready SHALL be 0 that cycle.
REQ-028 i_flush asserted during a stall SHALL also clear valids; flush takes priority over stall.
REQ-029 Data registers of invalid stages are don't-care; o_out and o_carry SHALL be meaningful only while o_valid = 1.

Reset
REQ-030 i_rst SHALL asynchronously clear all stage valid bits; o_valid = 0 and o_ready = 1 immediately.
REQ-031 After reset, o_out and o_carry SHALL read 0; data registers SHALL reset to 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operands; no result SHALL emerge after reset release without a new transfer in.

Structure
REQ-033 Package barrel_shift_pkg SHALL hold the mode encodings (MODE_LOG, MODE_ARI, MODE_ROT), the direction constants, and a clog2 function.
REQ-034 One sub-module, barrel_shift_level, SHALL implement a single combinational level (data, carry, fill) parameterised by WIDTH and LEVEL; the top SHALL generate LEVELS instances with registers between groups.

Verification (WIDTH=32, GROUP=2, PIPE=3)
REQ-035 i_in=0x80000001, rotate right, amount 1 -> o_out=0xC0000000, o_carry=1, o_valid exactly 3 cycles after accept.
REQ-036 i_in=0x80000000, arithmetic right, amount 31 -> o_out=0xFFFFFFFF, o_carry=0; logical right with the same operand -> o_out=0x00000001.
REQ-037 i_in=0x12345678, logical left, amount 4 -> o_out=0x23456780, o_carry=1; amount 0 with i_carry=1 -> o_out=0x12345678, o_carry=1.
REQ-038 Back-to-back 8 operands with i_ready low for cycles 3-5 -> no loss, no duplication, results in order, o_ready=0 exactly during the stall.
REQ-039 Flush with 3 operands in flight -> o_valid stays 0 until a new accepted operand completes 3 cycles later.
REQ-040 Assert i_rst asynchronously mid-stream -> o_valid falls without a clock edge; nothing emerges after release.
